// File: rtl/trng_arbiter_if.sv
// trng_arbiter_if: groups the TRNG fetch handshake and the consumer
// request/grant bus of trng_arbiter.
//   slave  (arbiter side): enable_i, rnd_ready_i, rnd_data_i, fail_i, req_i in;
//                          ack_read_o, gnt_o, rdata_o, err_o, level_o out
//   master (environment) : the same signals with directions reversed
interface trng_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WORD_W     = 32
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  logic               enable_i;
  logic               rnd_ready_i;
  logic [WORD_W-1:0]  rnd_data_i;
  logic               ack_read_o;
  logic               fail_i;
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [WORD_W-1:0]  rdata_o;
  logic               err_o;
  logic [LVL_W-1:0]   level_o;

  modport slave (
    input  enable_i, rnd_ready_i, rnd_data_i, fail_i, req_i,
    output ack_read_o, gnt_o, rdata_o, err_o, level_o
  );

  modport master (
    output enable_i, rnd_ready_i, rnd_data_i, fail_i, req_i,
    input  ack_read_o, gnt_o, rdata_o, err_o, level_o
  );
endinterface

// File: rtl/trng_arbiter.sv
// trng_arbiter: fetches TRNG words through a ready/ack-read handshake into a
// prefetch FIFO and hands each word to exactly one of NUM_REQ requesters,
// round robin. A TRNG failure purges the FIFO and turns every later grant into
// an error grant until reset.
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset
//   bus    trng_arbiter_if.slave (TRNG handshake, requests, grants, level)
module trng_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WORD_W     = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  trng_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_ACK  = 2'd1,
    F_LOW  = 2'd2
  } fetch_state_e;

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;

  logic [WORD_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;

  logic               r_fail;
  logic               r_ack;
  logic [NUM_REQ-1:0] r_gnt;
  logic [WORD_W-1:0]  r_rdata;
  logic               r_err;
  logic [PW-1:0]      r_ptr;

  logic               w_fail;
  logic               w_flush;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_ack_d;
  logic               w_grant;
  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [PW-1:0]      w_winner;
  logic [PW-1:0]      w_idx;

  // The live fail input acts in the same cycle so the purge lands on the next edge.
  assign w_fail  = bus.fail_i | r_fail;
  assign w_flush = ~bus.enable_i | w_fail;
  // Full is taken before any same-cycle pop.
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // Fetch FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= F_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Fetch FSM next state; F_LOW waits for ready to drop so each word is taken once.
  always_comb begin
    w_state_nxt = r_state;
    if (w_flush) begin
      w_state_nxt = F_IDLE;
    end else begin
      case (r_state)
        F_IDLE:  if (bus.rnd_ready_i && !w_full) w_state_nxt = F_ACK;
        F_ACK:   w_state_nxt = F_LOW;
        F_LOW:   if (!bus.rnd_ready_i) w_state_nxt = F_IDLE;
        default: w_state_nxt = F_IDLE;
      endcase
    end
  end

  // Fetch FSM outputs: push on the capture edge, ack registered for the F_ACK cycle.
  always_comb begin
    w_push  = 1'b0;
    w_ack_d = 1'b0;
    if (!w_flush && (r_state == F_IDLE) && bus.rnd_ready_i && !w_full) w_push = 1'b1;
    if (w_state_nxt == F_ACK) w_ack_d = 1'b1;
  end

  // Round-robin pick: first eligible requester at or after the pointer.
  always_comb begin
    w_eligible = bus.req_i & ~r_gnt;
    w_gnt_nxt  = '0;
    w_winner   = '0;
    w_idx      = '0;
    w_grant    = 1'b0;
    if (bus.enable_i && (w_fail || !w_empty)) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_idx = PW'((32'(r_ptr) + k) % NUM_REQ);
        if (!w_grant && w_eligible[w_idx]) begin
          w_grant          = 1'b1;
          w_winner         = w_idx;
          w_gnt_nxt[w_idx] = 1'b1;
        end
      end
    end
    // Error grants never consume entropy.
    w_pop = w_grant & ~w_fail;
  end

  // FIFO storage (no reset needed; occupancy is tracked by r_count).
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= bus.rnd_data_i;
  end

  // FIFO pointers, grant outputs, sticky fail flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_fail  <= 1'b0;
      r_ack   <= 1'b0;
      r_gnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_fail  <= w_fail;
      r_ack   <= w_ack_d;
      r_gnt   <= w_gnt_nxt;
      r_err   <= w_grant & w_fail;
      r_rdata <= w_pop ? r_mem[r_rptr] : '0;
      if (w_grant) r_ptr <= (w_winner == PW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= (r_wptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
        if (w_pop)  r_rptr <= (r_rptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign bus.ack_read_o = r_ack;
  assign bus.gnt_o      = r_gnt;
  assign bus.rdata_o    = r_rdata;
  assign bus.err_o      = r_err;
  assign bus.level_o    = r_count;
endmodule

// File: tb/tb_trng_arbiter.sv
// tb_trng_arbiter: directed self-checking bench for trng_arbiter.
module tb_trng_arbiter;
  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned WORD_W     = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   n_ack;

  always #5 clk = ~clk;

  trng_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH), .WORD_W(WORD_W)) bus ();

  trng_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH), .WORD_W(WORD_W)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Outputs are registered: sample 1 time unit after the edge, drive inputs there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.enable_i    = 1'b0;
    bus.rnd_ready_i = 1'b0;
    bus.rnd_data_i  = '0;
    bus.fail_i      = 1'b0;
    bus.req_i       = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full handshake: capture, ack cycle, ready low, back to F_IDLE.
  task automatic fetch_word(input logic [31:0] d);
    bus.rnd_data_i  = d;
    bus.rnd_ready_i = 1'b1;
    tick();
    chk("fetch_ack_high", 32'(bus.ack_read_o), 32'd1);
    bus.rnd_ready_i = 1'b0;
    tick();
    chk("fetch_ack_low", 32'(bus.ack_read_o), 32'd0);
    tick();
  endtask

  initial begin
    // Reset values
    do_reset();
    rst = 1'b1;
    tick();
    chk("rst_gnt",   32'(bus.gnt_o),      32'd0);
    chk("rst_rdata", bus.rdata_o,         32'd0);
    chk("rst_err",   32'(bus.err_o),      32'd0);
    chk("rst_ack",   32'(bus.ack_read_o), 32'd0);
    chk("rst_level", 32'(bus.level_o),    32'd0);
    rst = 1'b0;

    // Single fetch then grant
    bus.enable_i = 1'b1;
    fetch_word(32'hDEADBEEF);
    chk("single_level1", 32'(bus.level_o), 32'd1);
    bus.req_i = 4'b0001;
    tick();
    chk("single_gnt",    32'(bus.gnt_o),   32'h1);
    chk("single_rdata",  bus.rdata_o,      32'hDEADBEEF);
    chk("single_err",    32'(bus.err_o),   32'd0);
    chk("single_level0", 32'(bus.level_o), 32'd0);
    bus.req_i = '0;
    tick();
    chk("single_gnt_drop",   32'(bus.gnt_o), 32'd0);
    chk("single_rdata_zero", bus.rdata_o,    32'd0);

    // Simultaneous push and pop keeps the level
    fetch_word(32'h11111111);
    bus.rnd_data_i  = 32'h22222222;
    bus.rnd_ready_i = 1'b1;
    bus.req_i       = 4'b0010;
    tick();
    chk("pp_gnt",   32'(bus.gnt_o),      32'h2);
    chk("pp_rdata", bus.rdata_o,         32'h11111111);
    chk("pp_ack",   32'(bus.ack_read_o), 32'd1);
    chk("pp_level", 32'(bus.level_o),    32'd1);
    bus.rnd_ready_i = 1'b0;
    bus.req_i       = '0;
    tick();
    tick();

    // Round robin from pointer 0
    do_reset();
    bus.enable_i = 1'b1;
    fetch_word(32'hA0A0A0A0);
    fetch_word(32'hB1B1B1B1);
    fetch_word(32'hC2C2C2C2);
    fetch_word(32'hD3D3D3D3);
    chk("rr_level4", 32'(bus.level_o), 32'd4);
    bus.req_i = 4'b1111;
    tick();
    chk("rr_gnt0",   32'(bus.gnt_o), 32'h1);
    chk("rr_data0",  bus.rdata_o,    32'hA0A0A0A0);
    tick();
    chk("rr_gnt1",   32'(bus.gnt_o), 32'h2);
    chk("rr_data1",  bus.rdata_o,    32'hB1B1B1B1);
    tick();
    chk("rr_gnt2",   32'(bus.gnt_o), 32'h4);
    chk("rr_data2",  bus.rdata_o,    32'hC2C2C2C2);
    tick();
    chk("rr_gnt3",   32'(bus.gnt_o), 32'h8);
    chk("rr_data3",  bus.rdata_o,    32'hD3D3D3D3);
    chk("rr_level0", 32'(bus.level_o), 32'd0);
    tick();
    chk("rr_empty_nognt", 32'(bus.gnt_o), 32'd0);
    bus.req_i = '0;
    fetch_word(32'hE4E4E4E4);
    bus.req_i = 4'b1111;
    tick();
    chk("rr_wrap_gnt",  32'(bus.gnt_o), 32'h1);
    chk("rr_wrap_data", bus.rdata_o,    32'hE4E4E4E4);
    bus.req_i = '0;
    tick();

    // Full FIFO holds with ready stuck high
    fetch_word(32'h00000001);
    fetch_word(32'h00000002);
    fetch_word(32'h00000003);
    fetch_word(32'h00000004);
    bus.rnd_data_i  = 32'h55555555;
    bus.rnd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_no_ack", 32'(bus.ack_read_o), 32'd0);
      chk("full_level",  32'(bus.level_o),    32'd4);
    end
    bus.enable_i = 1'b0;
    tick();
    chk("full_flush_level", 32'(bus.level_o), 32'd0);
    bus.enable_i = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_ack += int'(bus.ack_read_o);
    end
    chk("stuck_ready_acks",  32'(n_ack),        32'd1);
    chk("stuck_ready_level", 32'(bus.level_o),  32'd1);

    // Disable flush
    bus.rnd_ready_i = 1'b0;
    tick();
    fetch_word(32'h66666666);
    fetch_word(32'h77777777);
    chk("dis_level3", 32'(bus.level_o), 32'd3);
    bus.enable_i = 1'b0;
    bus.req_i    = 4'b0011;
    tick();
    chk("dis_level0", 32'(bus.level_o), 32'd0);
    chk("dis_nognt0", 32'(bus.gnt_o),   32'd0);
    tick();
    chk("dis_nognt1", 32'(bus.gnt_o),   32'd0);
    bus.req_i    = '0;
    bus.enable_i = 1'b1;

    // Failure: purge, no more acks, error grants, sticky
    fetch_word(32'h88888888);
    fetch_word(32'h99999999);
    chk("fail_level2", 32'(bus.level_o), 32'd2);
    bus.fail_i = 1'b1;
    tick();
    chk("fail_level0", 32'(bus.level_o),    32'd0);
    chk("fail_ack0",   32'(bus.ack_read_o), 32'd0);
    bus.fail_i      = 1'b0;
    bus.rnd_data_i  = 32'hABABABAB;
    bus.rnd_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fail_no_ack",   32'(bus.ack_read_o), 32'd0);
      chk("fail_no_level", 32'(bus.level_o),    32'd0);
    end
    bus.rnd_ready_i = 1'b0;
    bus.req_i       = 4'b0100;
    tick();
    chk("fail_gnt",   32'(bus.gnt_o), 32'h4);
    chk("fail_err",   32'(bus.err_o), 32'd1);
    chk("fail_rdata", bus.rdata_o,    32'd0);
    bus.req_i = '0;
    tick();
    chk("fail_gnt_drop", 32'(bus.gnt_o), 32'd0);
    chk("fail_err_drop", 32'(bus.err_o), 32'd0);
    bus.req_i = 4'b0001;
    tick();
    chk("fail_sticky_gnt", 32'(bus.gnt_o), 32'h1);
    chk("fail_sticky_err", 32'(bus.err_o), 32'd1);
    bus.req_i = '0;
    do_reset();
    bus.enable_i = 1'b1;
    bus.req_i    = 4'b0001;
    tick();
    chk("fail_cleared_nognt", 32'(bus.gnt_o), 32'd0);
    chk("fail_cleared_err",   32'(bus.err_o), 32'd0);
    bus.req_i = '0;

    // Reset in the cycle a grant is decided
    fetch_word(32'h0BADF00D);
    chk("rmg_level1", 32'(bus.level_o), 32'd1);
    bus.req_i = 4'b0001;
    rst       = 1'b1;
    tick();
    chk("rmg_gnt",   32'(bus.gnt_o),      32'd0);
    chk("rmg_rdata", bus.rdata_o,         32'd0);
    chk("rmg_err",   32'(bus.err_o),      32'd0);
    chk("rmg_ack",   32'(bus.ack_read_o), 32'd0);
    chk("rmg_level", 32'(bus.level_o),    32'd0);
    rst       = 1'b0;
    bus.req_i = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
